pcm_i2s_tx: RTL and testbench

PCM_I2S_TX -- requirements
Module: pcm_i2s_tx

---
 rtl/mp3dec_pkg.sv | 27 ++
 rtl/i2s_clkdiv.sv | 32 +++
 rtl/pcm_i2s_tx.sv | 116 +++++++++++
 tb/tb_pcm_i2s_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3dec_pkg.sv
// Shared constants for the PCM-to-I2S transmit path: FSM encodings, frame geometry
// and the frame-image helper used to load the output shift register.
package mp3dec_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREFETCH = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_DRAIN    = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    PREFETCH = ST_PREFETCH,
    RUN      = ST_RUN,
    DRAIN    = ST_DRAIN
  } tx_state_t;

  localparam int unsigned FRAME_SLOTS = 64;
  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned SLOT_W      = 6;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_SLOTS - 1);

  // Frame image, MSB first: left sample, 16 pad bits, right sample, 16 pad bits.
  function automatic logic [FRAME_SLOTS-1:0] frame_bits(input logic [2*SAMPLE_W-1:0] w);
    return {w[2*SAMPLE_W-1:SAMPLE_W], {SAMPLE_W{1'b0}}, w[SAMPLE_W-1:0], {SAMPLE_W{1'b0}}};
  endfunction

endpackage

// File: rtl/i2s_clkdiv.sv
// BCLK generator: counts 0..div then toggles bclk; rise/fall are combinational
// strobes valid in the Clk cycle whose closing edge performs the toggle.
module i2s_clkdiv (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] div,
  output logic       bclk,
  output logic       rise,
  output logic       fall
);

  logic [7:0] cnt;
  logic       tc;

  assign tc   = en && (cnt == div);
  assign rise = tc && !bclk;
  assign fall = tc && bclk;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (tc) begin
      cnt  <= '0;
      bclk <= ~bclk;
    end else begin
      cnt  <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/pcm_i2s_tx.sv
// PCM FIFO to I2S serializer: one-word holding register prefetched from the FIFO,
// 64-slot frames with a one-bit I2S delay, saturating underrun counter.
module pcm_i2s_tx
  import mp3dec_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Enable,
  input  logic [7:0]       clk_div,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  input  logic [31:0]      fifo_datain,
  output logic             i2s_bclk,
  output logic             i2s_lrck,
  output logic             i2s_sdata,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic             busy
);

  tx_state_t              state, state_nxt;
  logic [7:0]             div_q;
  logic [31:0]            hold;
  logic                   hold_valid;
  logic                   rd_pend;
  logic [FRAME_SLOTS-1:0] sh;
  logic                   next_bit;
  logic [SLOT_W-1:0]      slot;
  logic                   bclk_rise, bclk_fall;
  logic                   frame_end, run_entry, load_frame;

  i2s_clkdiv u_clkdiv (
    .clk  (Clk),
    .rst  (Rst),
    .en   ((state == RUN) || (state == DRAIN)),
    .div  (div_q),
    .bclk (i2s_bclk),
    .rise (bclk_rise),
    .fall (bclk_fall)
  );

  assign frame_end  = bclk_fall && (slot == LAST_SLOT);
  assign run_entry  = (state == PREFETCH) && (state_nxt == RUN);
  assign load_frame = run_entry || ((state == RUN) && frame_end);
  assign i2s_lrck   = slot[SLOT_W-1];
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    fifo_ren  = 1'b0;
    case (state)
      IDLE:     if (Enable) state_nxt = PREFETCH;
      PREFETCH: begin
        if (!Enable)         state_nxt = IDLE;
        else if (hold_valid) state_nxt = RUN;
      end
      RUN:      if (!Enable) state_nxt = DRAIN;
      DRAIN:    if (frame_end) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (Enable && !Rst && ((state == PREFETCH) || (state == RUN)) &&
        !hold_valid && !rd_pend && !fifo_empty)
      fifo_ren = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      div_q        <= '0;
      hold         <= '0;
      hold_valid   <= 1'b0;
      rd_pend      <= 1'b0;
      sh           <= '0;
      next_bit     <= 1'b0;
      slot         <= '0;
      i2s_sdata    <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rd_pend  <= fifo_ren;
      underrun <= 1'b0;
      if ((state == IDLE) && Enable)
        div_q <= clk_div;

      // Next slot's bit is staged on the BCLK rise and driven on the following fall.
      if (load_frame) begin
        sh         <= hold_valid ? frame_bits(hold) : '0;
        hold_valid <= 1'b0;
        if (!hold_valid) begin
          underrun <= 1'b1;
          if (underrun_cnt != '1)
            underrun_cnt <= underrun_cnt + CNT_W'(1);
        end
      end else if (bclk_rise) begin
        next_bit <= sh[FRAME_SLOTS-1];
        sh       <= {sh[FRAME_SLOTS-2:0], 1'b0};
      end

      if (bclk_fall) begin
        slot      <= slot + SLOT_W'(1);
        i2s_sdata <= next_bit;
      end

      if (rd_pend) begin
        hold       <= fifo_datain;
        hold_valid <= 1'b1;
      end
      if ((state != IDLE) && (state_nxt == IDLE))
        hold_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Directed bench for pcm_i2s_tx: table of PCM words with hand-derived serial bit
// patterns, plus underrun, drain, mid-frame reset, saturation and streaming sequences.
module tb_pcm_i2s_tx;

  typedef struct {
    logic [31:0] word;
    logic [15:0] left_bits;
    logic [15:0] right_bits;
  } vec_t;

  vec_t vecs [4];

  logic        Clk = 1'b0;
  logic        Rst, Enable;
  logic [7:0]  clk_div;
  logic        fifo_empty, fifo_ren;
  logic [31:0] fifo_datain = '0;
  logic        i2s_bclk, i2s_lrck, i2s_sdata, underrun, busy;
  logic [15:0] underrun_cnt;

  logic        Enable4, fifo_empty4, fifo_ren4;
  logic        bclk4, lrck4, sdata4, underrun4, busy4;
  logic [3:0]  underrun_cnt4;

  logic [31:0] fmem [0:255];
  int wp = 0, rp = 0;
  int f4_pushed = 0, f4_popped = 0;

  assign fifo_empty  = (wp == rp);
  assign fifo_empty4 = (f4_pushed == f4_popped);

  always #5 Clk = ~Clk;

  pcm_i2s_tx u_dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .clk_div(clk_div),
    .fifo_empty(fifo_empty), .fifo_ren(fifo_ren), .fifo_datain(fifo_datain),
    .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
    .underrun(underrun), .underrun_cnt(underrun_cnt), .busy(busy)
  );

  pcm_i2s_tx #(.CNT_W(4)) u_dut4 (
    .Clk(Clk), .Rst(Rst), .Enable(Enable4), .clk_div(8'd0),
    .fifo_empty(fifo_empty4), .fifo_ren(fifo_ren4), .fifo_datain(32'hA5A5_5A5A),
    .i2s_bclk(bclk4), .i2s_lrck(lrck4), .i2s_sdata(sdata4),
    .underrun(underrun4), .underrun_cnt(underrun_cnt4), .busy(busy4)
  );

  // FIFO responders: word appears on fifo_datain the cycle after the strobe.
  always @(posedge Clk) begin
    if (fifo_ren) begin
      fifo_datain <= fmem[rp[7:0]];
      rp <= rp + 1;
    end
    if (fifo_ren4) f4_popped <= f4_popped + 1;
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic log_sd [0:8191];
  logic log_lr [0:8191];
  int   log_t  [0:8191];
  int   nrise = 0, ren_cnt = 0, consec = 0, ur_pulses = 0, ur_cycles = 0, ur4 = 0;
  int   busy_fall_t = 0;
  logic prev_bclk = 1'b0, prev_busy = 1'b0, prev_ren = 1'b0, prev_ur = 1'b0;

  always @(negedge Clk) begin
    if (i2s_bclk === 1'b1 && prev_bclk === 1'b0 && nrise < 8192) begin
      log_sd[nrise] = i2s_sdata;
      log_lr[nrise] = i2s_lrck;
      log_t[nrise]  = cyc;
      nrise = nrise + 1;
    end
    if (fifo_ren === 1'b1) begin
      ren_cnt = ren_cnt + 1;
      if (prev_ren === 1'b1) consec = consec + 1;
    end
    if (underrun === 1'b1) begin
      ur_cycles = ur_cycles + 1;
      if (prev_ur !== 1'b1) ur_pulses = ur_pulses + 1;
    end
    if (prev_busy === 1'b1 && busy === 1'b0) busy_fall_t = cyc;
    if (underrun4 === 1'b1) ur4 = ur4 + 1;
    prev_bclk = i2s_bclk;
    prev_busy = busy;
    prev_ren  = fifo_ren;
    prev_ur   = underrun;
  end

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic push(input logic [31:0] w);
    fmem[wp[7:0]] = w;
    wp = wp + 1;
  endtask

  task automatic wait_rises(input int target, input int limit, input string name);
    int n = 0;
    while (nrise < target && n < limit) begin tick(); n++; end
    if (nrise < target) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s timeout: got %0d rises expected %0d", name, nrise, target);
    end
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (busy && n < limit) begin tick(); n++; end
    check({name, " idle"}, busy, 1'b0);
  endtask

  task automatic check_frame(input int b, input logic [15:0] el, input logic [15:0] er,
                             input string tag);
    logic [15:0] l = '0, r = '0;
    int others = 0, lrbad = 0;
    for (int s = 0; s < 64; s++) begin
      if (s >= 1 && s <= 16)       l = {l[14:0], log_sd[b+s]};
      else if (s >= 33 && s <= 48) r = {r[14:0], log_sd[b+s]};
      else if (log_sd[b+s] !== 1'b0) others++;
      if (log_lr[b+s] !== (s >= 32)) lrbad++;
    end
    check({tag, " left"},  l, el);
    check({tag, " right"}, r, er);
    check({tag, " pad"},   others, 0);
    check({tag, " lrck"},  lrbad, 0);
  endtask

  task automatic check_period(input int b, input int n, input int p, input string name);
    int bad = 0;
    for (int k = 1; k < n; k++)
      if (log_t[b+k] - log_t[b+k-1] != p) bad++;
    check(name, bad, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " bclk"},  i2s_bclk, 1'b0);
    check({tag, " lrck"},  i2s_lrck, 1'b0);
    check({tag, " sdata"}, i2s_sdata, 1'b0);
    check({tag, " ren"},   fifo_ren, 1'b0);
    check({tag, " und"},   underrun, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, ren0, u0, uc0, n;
    logic [15:0] h;

    vecs[0] = '{32'h8001_7FFE, 16'b1000_0000_0000_0001, 16'b0111_1111_1111_1110};
    vecs[1] = '{32'hFFFF_0000, 16'b1111_1111_1111_1111, 16'b0000_0000_0000_0000};
    vecs[2] = '{32'h1234_A5C3, 16'b0001_0010_0011_0100, 16'b1010_0101_1100_0011};
    vecs[3] = '{32'h0000_0001, 16'b0000_0000_0000_0000, 16'b0000_0000_0000_0001};

    Rst = 1'b1; Enable = 1'b0; Enable4 = 1'b0; clk_div = 8'd1;
    repeat (3) tick();
    Rst = 1'b0;
    tick();
    check_quiet("reset");
    check("reset cnt", underrun_cnt, 16'd0);
    check("reset busy", busy, 1'b0);

    // Four table words streamed, Enable dropped at frame 3 slot 10.
    for (int i = 0; i < 4; i++) push(vecs[i].word);
    base = nrise; ren0 = ren_cnt; u0 = ur_pulses;
    Enable = 1'b1;
    repeat (10) tick();
    clk_div = 8'd5;
    wait_rises(base + 3*64 + 11, 2000, "A slot");
    Enable = 1'b0;
    wait_idle(600, "A");
    repeat (4) tick();
    check("A rises", nrise - base, 256);
    for (int f = 0; f < 4; f++)
      check_frame(base + f*64, vecs[f].left_bits, vecs[f].right_bits, $sformatf("A f%0d", f));
    check_period(base, 256, 4, "A bclk period");
    check("A busy fall", busy_fall_t - log_t[base], 1022);
    check_quiet("A idle");
    check("A reads", ren_cnt - ren0, 4);
    check("A underruns", ur_pulses - u0, 0);

    // One word then three empty frames.
    clk_div = 8'd1;
    ren0 = ren_cnt; u0 = ur_pulses; uc0 = ur_cycles;
    push(vecs[2].word);
    base = nrise;
    Enable = 1'b1;
    wait_rises(base + 3*64 + 11, 2000, "B slot");
    Enable = 1'b0;
    wait_idle(600, "B");
    check_frame(base, vecs[2].left_bits, vecs[2].right_bits, "B f0");
    for (int f = 1; f < 4; f++)
      check_frame(base + f*64, 16'h0000, 16'h0000, $sformatf("B f%0d", f));
    check("B pulses", ur_pulses - u0, 3);
    check("B pulse cycles", ur_cycles - uc0, 3);
    check("B cnt", underrun_cnt, 16'd3);
    check("B reads", ren_cnt - ren0, 1);

    // Reset in slot 40 with Enable still high.
    push(vecs[0].word);
    push(vecs[1].word);
    base = nrise;
    Enable = 1'b1;
    wait_rises(base + 41, 500, "C slot");
    check("C lrck slot40", i2s_lrck, 1'b1);
    check("C cnt before", underrun_cnt, 16'd3);
    Rst = 1'b1;
    tick();
    check_quiet("C reset");
    check("C busy", busy, 1'b0);
    check("C cnt", underrun_cnt, 16'd0);
    repeat (3) tick();
    check("C held busy", busy, 1'b0);
    Rst = 1'b0; Enable = 1'b0;
    tick();

    // 100 frames from a continuously full FIFO.
    clk_div = 8'd0;
    for (int i = 0; i < 101; i++) begin
      h = 16'(i);
      push({h, ~h});
    end
    base = nrise; ren0 = ren_cnt; u0 = ur_pulses;
    Enable = 1'b1;
    wait_rises(base + 99*64 + 11, 15000, "D slot");
    Enable = 1'b0;
    wait_idle(400, "D");
    check("D rises", nrise - base, 6400);
    check("D reads", ren_cnt - ren0, 101);
    check("D underruns", ur_pulses - u0, 0);
    check("D consecutive ren", consec, 0);
    check_period(base, 6400, 2, "D bclk period");
    check_frame(base + 99*64, 16'd99, ~16'd99, "D f99");

    // Narrow counter saturates.
    f4_pushed = 1;
    Enable4 = 1'b1;
    n = 0;
    while (ur4 < 20 && n < 5000) begin tick(); n++; end
    check("E underruns seen", ur4 >= 20, 1'b1);
    Enable4 = 1'b0;
    n = 0;
    while (busy4 && n < 400) begin tick(); n++; end
    check("E busy", busy4, 1'b0);
    check("E cnt sat", underrun_cnt4, 4'd15);
    check("E quiet", {bclk4, lrck4, sdata4}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
